// File: rtl/ripple_carry_adder.sv
// Unsigned ripple-carry adder: a chain of explicit full-adder cells feeding a
// single output register stage with valid, carry-out and signed-overflow flags.

module rca_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    assign s  = p ^ ci;
    assign co = (a & b) | (ci & p);
endmodule

module ripple_carry_adder #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    input  logic             in_valid,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic             Ovf,
    output logic             out_valid
);
    // c[i] is the carry into bit i; c[WIDTH] is the carry out of the MSB
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;
    logic             ovf;

    assign c[0] = Cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        rca_fa_cell u_fa (
            .a  (A[i]),
            .b  (B[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    // With WIDTH=1 the carry into the MSB is Cin itself
    assign ovf = c[WIDTH] ^ c[WIDTH-1];

    // Result registers only load on a valid op, so idle/X inputs never leak out
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            Sum       <= '0;
            Cout      <= 1'b0;
            Ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                Sum  <= s;
                Cout <= c[WIDTH];
                Ovf  <= ovf;
            end
        end
    end
endmodule

// File: tb/tb_ripple_carry_adder.sv
// Directed and exhaustive checks of ripple_carry_adder at WIDTH=4.

module tb_ripple_carry_adder;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [W-1:0] A, B;
    logic         Cin, in_valid;
    logic [W-1:0] Sum;
    logic         Cout, Ovf, out_valid;

    int checks   = 0;
    int failures = 0;

    ripple_carry_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
        .in_valid  (in_valid),
        .Sum       (Sum),
        .Cout      (Cout),
        .Ovf       (Ovf),
        .out_valid (out_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_out(input string nm, input logic v, input logic [W-1:0] s,
                           input logic co, input logic ov);
        chk({nm, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
        chk({nm, ".sum"},       {28'd0, Sum},       {28'd0, s});
        chk({nm, ".cout"},      {31'd0, Cout},      {31'd0, co});
        chk({nm, ".ovf"},       {31'd0, Ovf},       {31'd0, ov});
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ci);
        in_valid = v;
        A        = a;
        B        = b;
        Cin      = ci;
    endtask

    initial begin
        vec_t tbl[8];
        logic [W:0]   full;
        logic [W-1:0] pa, pb;
        logic         pc, pov;

        tbl[0] = '{4'd0,  4'd0,  1'b0, 4'b0000, 1'b0, 1'b0};
        tbl[1] = '{4'd5,  4'd3,  1'b0, 4'b1000, 1'b0, 1'b1};
        tbl[2] = '{4'd15, 4'd15, 1'b0, 4'b1110, 1'b1, 1'b0};
        tbl[3] = '{4'd15, 4'd15, 1'b1, 4'b1111, 1'b1, 1'b0};
        tbl[4] = '{4'd15, 4'd0,  1'b1, 4'b0000, 1'b1, 1'b0};
        tbl[5] = '{4'd7,  4'd1,  1'b0, 4'b1000, 1'b0, 1'b1};
        tbl[6] = '{4'd8,  4'd8,  1'b0, 4'b0000, 1'b1, 1'b1};
        tbl[7] = '{4'd6,  4'd1,  1'b1, 4'b1000, 1'b0, 1'b1};

        rst_n = 1'b0;
        drive(1'b0, '0, '0, 1'b0);
        #1 chk_out("reset_init", 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // back-to-back table vectors: check previous result, drive next
        for (int i = 0; i <= 8; i++) begin
            @(negedge clk);
            if (i > 0) chk_out($sformatf("tbl%0d", i - 1), 1'b1, tbl[i-1].sum,
                               tbl[i-1].cout, tbl[i-1].ovf);
            if (i < 8) drive(1'b1, tbl[i].a, tbl[i].b, tbl[i].cin);
            else       drive(1'b0, 'x, 'x, 1'bx);
        end

        // valid, idle (with X operands), valid
        @(negedge clk);
        chk_out("idle_after_tbl", 1'b0, tbl[7].sum, tbl[7].cout, tbl[7].ovf);
        drive(1'b1, 4'd2, 4'd3, 1'b0);
        @(negedge clk);
        chk_out("gate_2p3", 1'b1, 4'b0101, 1'b0, 1'b0);
        drive(1'b0, 'x, 'x, 1'bx);
        @(negedge clk);
        chk_out("gate_idle", 1'b0, 4'b0101, 1'b0, 1'b0);
        drive(1'b1, 4'd9, 4'd9, 1'b0);
        @(negedge clk);
        chk_out("gate_9p9", 1'b1, 4'b0010, 1'b1, 1'b1);

        // async reset with in_valid=1 and a live result on the outputs
        drive(1'b1, 4'd12, 4'd1, 1'b1);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk_out("async_reset", 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        chk_out("reset_held", 1'b0, 4'd0, 1'b0, 1'b0);

        // in-flight op at reset is discarded; first capture after release
        rst_n = 1'b1;
        drive(1'b1, 4'd4, 4'd4, 1'b0);
        #2 rst_n = 1'b0;
        @(posedge clk);
        #1 chk_out("inflight_drop", 1'b0, 4'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 4'd3, 4'd4, 1'b1);
        @(negedge clk);
        chk_out("first_after_rst", 1'b1, 4'b1000, 1'b0, 1'b1);

        // exhaustive A, B, Cin streamed back-to-back
        pa = '0; pb = '0; pc = 1'b0;
        for (int v = 0; v <= 512; v++) begin
            if (v > 0) begin
                @(negedge clk);
                full = {1'b0, pa} + {1'b0, pb} + {4'd0, pc};
                pov  = (pa[W-1] == pb[W-1]) && (full[W-1] != pa[W-1]);
                checks++;
                if (out_valid !== 1'b1 || {Cout, Sum} !== full || Ovf !== pov) begin
                    failures++;
                    $display("FAIL exh a=%0d b=%0d cin=%0d: got v=%0b cout=%0b sum=%0d ovf=%0b expected cout=%0b sum=%0d ovf=%0b",
                             pa, pb, pc, out_valid, Cout, Sum, Ovf, full[W], full[W-1:0], pov);
                end
            end else begin
                @(negedge clk);
            end
            if (v < 512) begin
                {pa, pb, pc} = 9'(v);
                drive(1'b1, pa, pb, pc);
            end else begin
                drive(1'b0, 'x, 'x, 1'bx);
            end
        end
        @(negedge clk);
        chk({"exh_tail.out_valid"}, {31'd0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
